apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

APB initiator that turns single-word commands from a local valid/ready request port into APB3 transfers and returns one response per command. It drives the same APB signal set the interrupt controller's slave port consumes (psel/penable/pwrite/paddr/pwdata in, prdata/pready/pslverr back). It replaces hand-sequenced bench stimulus and serves as the on-chip register-access master.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort (used only with timeout compiled in; legal range 1..255)

Ports:
- pclk_i  in  1  clock; all logic on rising edge
- rst_n_i  in  1  reset; synchronous and active-low
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  bridge can accept a command
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_W  byte address
- cmd_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  DATA_W  read data (0 for writes and errors)
- rsp_err_o  out  1  pslverr, misalignment or timeout
- rsp_timeout_o  out  1  error was a timeout (tied 0 without timeout)
- psel_o, penable_o, pwrite_o  out  1 each  APB control
- paddr_o  out  ADDR_W, pwdata_o  out  DATA_W  APB address/data
- prdata_i  in  DATA_W, pready_i  in  1, pslverr_i  in  1  APB slave response

## Operation
- States: IDLE, SETUP, ACCESS, RESP. Reset (rst_n_i low at a clock edge) forces IDLE from any state, including mid-ACCESS: all outputs 0 next cycle except cmd_ready_o=1; psel_o drops with no completion phase.
- IDLE: cmd_ready_o=1. On cmd_valid_i&&cmd_ready_o, latch write/addr/wdata. If cmd_addr_i[1:0]!=0 → RESP with rsp_err_o=1, no APB transfer. Otherwise → SETUP.
- SETUP: psel_o=1, penable_o=0, paddr_o/pwrite_o/pwdata_o from latched command → ACCESS unconditionally.
- ACCESS: psel_o=1, penable_o=1, signals unchanged. pready_i=0 → stay. pready_i=1 → capture prdata_i (reads only; writes capture 0) and pslverr_i into rsp_err_o; if pslverr_i=1, rsp_rdata_o=0; → RESP.
- RESP: psel_o=penable_o=0, rsp_valid_o=1, rsp fields stable until rsp_valid_o&&rsp_ready_i → IDLE.
- cmd_ready_o is 1 only in IDLE; one transfer outstanding at most. paddr_o/pwrite_o/pwdata_o hold last values when idle (0 after reset).
- pready_i/pslverr_i/prdata_i ignored outside ACCESS.

## Timing
- Command accepted at edge N: SETUP in cycle N+1, ACCESS from N+2; zero-wait-state slave gives rsp_valid_o in cycle N+3.
- Each wait state (pready_i=0 in ACCESS) adds one cycle.
- Response accepted at edge M: cmd_ready_o=1 in cycle M+1; minimum command-to-command period 4 cycles with rsp_ready_i tied 1.
- Misaligned command: rsp_valid_o in cycle N+1.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: an 8-bit counter clears on entering ACCESS and increments each ACCESS cycle without pready_i. When it reaches TIMEOUT_CYCLES, the bridge deasserts psel_o/penable_o and goes to RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0. pready_i in the same cycle as expiry wins: normal completion.
- Undefined: no counter, ACCESS waits indefinitely, rsp_timeout_o tied 0.

## Structure
- apb_master_pkg: state enum (IDLE/SETUP/ACCESS/RESP), default widths, timeout counter width constant.
- One sub-module, apb_master_timeout_cnt (clear, enable, expire output), instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write addr 0x0000_0004, data 0xDEAD_BEEF, pready_i=1 immediately → psel_o cycle N+1, penable_o cycle N+2, rsp_valid_o cycle N+3, rsp_err_o=0, rsp_rdata_o=0.
- Read addr 0x0000_0008, 3 wait states, prdata_i=0x0000_000F → penable_o high 4 cycles, rsp_rdata_o=0x0000_000F, rsp_valid_o held while rsp_ready_i=0 for 5 cycles.
- Write addr 0x0000_000C, pslverr_i=1 with pready_i → rsp_err_o=1, rsp_timeout_o=0, rsp_rdata_o=0.
- Read addr 0x0000_0003 → no psel_o pulse, rsp_valid_o cycle N+1, rsp_err_o=1.
- Timeout build, TIMEOUT_CYCLES=16, pready_i held 0 → penable_o drops after 16 ACCESS cycles, rsp_err_o=1, rsp_timeout_o=1; repeat with pready_i=1 on cycle 16 → normal completion.
- rst_n_i low during ACCESS of a read → next cycle psel_o=0, rsp_valid_o=0, cmd_ready_o=1; next command completes normally.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master bridge.
// No logic; state encoding, default widths and timeout counter width only.
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int APB_ADDR_W_DEF  = 32;
    localparam int APB_DATA_W_DEF  = 32;
    localparam int TO_CNT_W        = 8;
    localparam int TO_CYCLES_DEF   = 16;

    // APB transfers are word-sized; any nonzero byte offset is rejected locally.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/apb_master_timeout_cnt.sv
// ACCESS-phase wait counter: asserts expire on the wait cycle that would reach LIMIT.
// Latency: expire is combinational from the count and enable.
// Backpressure: none; counts only while enabled, clear has priority.
module apb_master_timeout_cnt
    import apb_master_pkg::*;
#(
    parameter int LIMIT = TO_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(LIMIT - 1);

    logic [TO_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q holds completed waits, so this wait is the LIMIT-th one.
    assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB3 initiator, one outstanding transfer; optional ACCESS timeout (APB_MASTER_TIMEOUT_EN).
// Latency: accept N -> SETUP N+1, ACCESS N+2, response N+3 (+1 per wait state); misaligned -> response N+1.
// Backpressure: cmd_ready_o only in IDLE; response held in RESP until rsp_ready_i.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W_DEF,
    parameter int DATA_W         = APB_DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TO_CYCLES_DEF
) (
    input  logic              pclk_i,
    input  logic              rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    apb_state_e        state_q;
    apb_state_e        state_d;
    logic              to_expire;
    logic              cmd_acc;
    logic              cmd_bad;

    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    assign cmd_acc = (state_q == ST_IDLE) && cmd_valid_i;
    assign cmd_bad = is_misaligned(cmd_addr_i[1:0]);

    always_ff @(posedge pclk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    state_d = cmd_bad ? ST_RESP : ST_SETUP;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (pready_i || to_expire) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the state register only, so no input reaches an output combinationally.
    always_comb begin
        cmd_ready_o = 1'b0;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            ST_IDLE:   cmd_ready_o = 1'b1;
            ST_SETUP:  psel_o      = 1'b1;
            ST_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
            end
            ST_RESP:   rsp_valid_o = 1'b1;
            default:   cmd_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (!rst_n_i) begin
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (cmd_acc) begin
            pwrite_q    <= cmd_write_i;
            paddr_q     <= cmd_addr_i;
            pwdata_q    <= cmd_wdata_i;
            rsp_rdata_q <= '0;
            rsp_err_q   <= cmd_bad;
        end else if (state_q == ST_ACCESS) begin
            if (pready_i) begin
                rsp_err_q   <= pslverr_i;
                rsp_rdata_q <= (!pwrite_q && !pslverr_i) ? prdata_i : '0;
            end else if (to_expire) begin
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
    logic rsp_to_q;

    apb_master_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (pclk_i),
        .rst_n  (rst_n_i),
        .clr    (state_q == ST_SETUP),
        .en     ((state_q == ST_ACCESS) && !pready_i),
        .expire (to_expire)
    );

    always_ff @(posedge pclk_i) begin
        if (!rst_n_i) begin
            rsp_to_q <= 1'b0;
        end else if (cmd_acc) begin
            rsp_to_q <= 1'b0;
        end else if ((state_q == ST_ACCESS) && !pready_i && to_expire) begin
            rsp_to_q <= 1'b1;
        end
    end

    assign rsp_timeout_o = rsp_to_q;
`else
    logic unused_timeout_cfg;

    assign to_expire          = 1'b0;
    assign rsp_timeout_o      = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: aligned/misaligned commands, wait states, slave errors, reset in ACCESS.
// Timeout vectors are exercised when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

    logic        pclk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks   = 0;
    int failures = 0;
    int cnt;

    apb_master_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk_i        (pclk),
        .rst_n_i       (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .psel_o        (psel),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .paddr_o       (paddr),
        .pwdata_o      (pwdata),
        .prdata_i      (prdata),
        .pready_i      (pready),
        .pslverr_i     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle 1ns so sampling and driving sit away from the edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic start_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 40 && !rsp_valid; i++) tick();
        check({tag, "_rsp_seen"}, rsp_valid, 1'b1);
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_ctl", {cmd_ready, psel, penable, rsp_valid, rsp_err, rsp_timeout}, 6'b100000);
        check("reset_bus", {paddr, pwdata}, 64'h0);

        // Zero-wait write
        pready = 1'b1;
        start_cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
        check("wr_setup_ctl", {psel, penable, pwrite, cmd_ready, rsp_valid}, 5'b10100);
        check("wr_setup_bus", {paddr, pwdata}, {32'h0000_0004, 32'hDEAD_BEEF});
        tick();
        check("wr_access_ctl", {psel, penable, rsp_valid}, 3'b110);
        tick();
        check("wr_resp_ctl", {psel, penable, rsp_valid, rsp_err, rsp_timeout}, 5'b00100);
        check("wr_resp_rdata", rsp_rdata, 32'h0);
        ack_rsp();
        check("wr_done_ctl", {cmd_ready, rsp_valid}, 2'b10);
        check("wr_idle_hold", {paddr, pwdata}, {32'h0000_0004, 32'hDEAD_BEEF});

        // Read with three wait states; prdata only valid on the completing cycle
        pready = 1'b0;
        prdata = 32'h0000_0055;
        start_cmd(1'b0, 32'h0000_0008, 32'h0);
        tick();
        cnt = 0;
        for (int i = 0; i < 20 && penable; i++) begin
            cnt++;
            if (cnt == 4) begin
                pready = 1'b1;
                prdata = 32'h0000_000F;
            end
            tick();
        end
        pready = 1'b0;
        prdata = 32'h0000_0077;
        check("rd_penable_cycles", cnt, 4);
        check("rd_resp_ctl", {rsp_valid, rsp_err, psel}, 3'b100);
        check("rd_rdata", rsp_rdata, 32'h0000_000F);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid && rsp_rdata == 32'h0000_000F) cnt++;
            tick();
        end
        check("rd_rsp_held", cnt, 5);
        ack_rsp();
        check("rd_done_ready", cmd_ready, 1'b1);

        // Slave error on write, then on a read with nonzero prdata
        pready  = 1'b1;
        pslverr = 1'b1;
        start_cmd(1'b1, 32'h0000_000C, 32'h1234_5678);
        wait_rsp("wr_err");
        check("wr_err_fields", {rsp_err, rsp_timeout}, 2'b10);
        check("wr_err_rdata", rsp_rdata, 32'h0);
        ack_rsp();
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hA5A5_A5A5;
        start_cmd(1'b0, 32'h0000_0010, 32'h0);
        wait_rsp("rd_err");
        check("rd_err_fields", {rsp_err, rsp_rdata}, {1'b1, 32'h0});
        ack_rsp();

        // Misaligned read: local error, no APB activity
        pready = 1'b1;
        start_cmd(1'b0, 32'h0000_0003, 32'h0);
        check("mis_resp", {rsp_valid, rsp_err, rsp_timeout, psel, penable}, 5'b11000);
        check("mis_rdata", rsp_rdata, 32'h0);
        ack_rsp();
        check("mis_done_ready", cmd_ready, 1'b1);

        // Long wait: expires at 16 cycles with timeout, never without
        pready = 1'b0;
        prdata = 32'h0000_0042;
        start_cmd(1'b0, 32'h0000_0020, 32'h0);
        tick();
        cnt = 0;
        for (int i = 0; i < 30 && penable; i++) begin
            cnt++;
            tick();
        end
`ifdef APB_MASTER_TIMEOUT_EN
        check("to_cycles", cnt, 16);
        check("to_resp", {rsp_valid, rsp_err, rsp_timeout, psel, rsp_rdata}, {4'b1110, 32'h0});
        ack_rsp();
        pready = 1'b0;
        prdata = 32'h0000_0099;
        start_cmd(1'b0, 32'h0000_0024, 32'h0);
        tick();
        cnt = 0;
        for (int i = 0; i < 30 && penable; i++) begin
            cnt++;
            if (cnt == 16) pready = 1'b1;
            tick();
        end
        check("to_race_cycles", cnt, 16);
        check("to_race_resp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 32'h0000_0099});
        ack_rsp();
`else
        check("nto_still_waiting", {cnt, psel, penable, rsp_valid}, {32'd30, 3'b110});
        pready = 1'b1;
        tick();
        check("nto_resp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 32'h0000_0042});
        ack_rsp();
`endif

        // Reset during ACCESS of a read
        pready = 1'b0;
        start_cmd(1'b0, 32'h0000_0014, 32'h0);
        tick();
        check("rst_in_access", {psel, penable}, 2'b11);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_ctl", {psel, penable, rsp_valid, cmd_ready, rsp_err}, 5'b00010);
        check("rst_bus", {paddr, pwdata}, 64'h0);
        pready = 1'b1;
        prdata = 32'h0000_1234;
        start_cmd(1'b0, 32'h0000_0018, 32'h0);
        check("post_rst_setup", {psel, penable, paddr}, {2'b10, 32'h0000_0018});
        wait_rsp("post_rst");
        check("post_rst_resp", {rsp_err, rsp_rdata}, {1'b0, 32'h0000_1234});
        ack_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
